// File: rtl/spi_cmd_queue.sv
// SPI command receiver with an in-order, per-channel dispatch queue.
// SPI frames are shifted in through synchronised pins and checked for a
// valid channel. Good frames go into a small FIFO. The head entry is handed
// to its accelerator channel as soon as that channel reports ready.
module spi_cmd_queue #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int NCH     = 2,
  parameter int DEPTH   = 4,
  localparam int CHW     = (NCH > 2) ? $clog2(NCH) : 1,
  localparam int FRAME_W = 1 + OPCODEW + CHW + 3 * ADDRW,
  localparam int CNTW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_clk,
  input  logic               mosi,
  input  logic               cs_n,
  input  logic [NCH-1:0]     ready_in,
  input  logic               clr_err,
  output logic [NCH-1:0]     cmd_valid,
  output logic               cmd_vbit,
  output logic [OPCODEW-1:0] opcode,
  output logic [ADDRW-1:0]   key_addr,
  output logic [ADDRW-1:0]   text_addr,
  output logic [ADDRW-1:0]   dest_addr,
  output logic [CNTW-1:0]    fifo_count,
  output logic               overflow,
  output logic               frame_err
);

  localparam int BCW  = $clog2(FRAME_W + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);

  // The packed field order matches the wire order, MSB first.
  typedef struct packed {
    logic               vbit;
    logic [OPCODEW-1:0] opcode;
    logic [CHW-1:0]     ch;
    logic [ADDRW-1:0]   key;
    logic [ADDRW-1:0]   text;
    logic [ADDRW-1:0]   dest;
  } frame_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_s, mosi_s, cs_s;
  logic       sample, cs_rise;

  // Two-flop synchronisers plus one history flop for edge detection.
  // cs_n flops reset to 1, so the bus looks idle right after reset.
  // NOTE: all clocked state uses non-blocking (<=) assignments. Each flop
  // then sees the value its neighbours had before this edge, which is what
  // makes the shift chains below behave as real flop chains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs_n};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sclk_s  = sclk_sync[1];
  assign mosi_s  = mosi_sync[1];
  assign cs_s    = cs_sync[1];
  assign sample  = sclk_s & ~sclk_prev & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev;

  // ---------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------
  logic [FRAME_W-1:0] shift;
  logic [BCW-1:0]     bit_cnt;
  logic               frame_rdy;
  frame_t             frame;
  logic               ch_ok, push_req;

  assign frame    = frame_t'(shift);
  assign ch_ok    = {1'b0, frame.ch} < NCH_W;
  assign push_req = frame_rdy & ch_ok;

  // Shift in bits MSB first, up to one full frame per CS window. Report an
  // error for a window that closes early or for a frame whose channel is
  // out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      frame_rdy <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_rdy <= 1'b0;
      frame_err <= frame_rdy & ~ch_ok;
      if (cs_rise) begin
        bit_cnt <= '0;
        if (bit_cnt != '0 && bit_cnt < BCW'(FRAME_W)) frame_err <= 1'b1;
      end else if (sample && bit_cnt < BCW'(FRAME_W)) begin
        shift   <= {shift[FRAME_W-2:0], mosi_s};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == BCW'(FRAME_W - 1)) frame_rdy <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  frame_t          mem [DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  frame_t          head;
  logic            head_ready, pop, push, drop;

  assign head = mem[rd_ptr];

  // Only the ready bit of the head entry's channel matters. A ready
  // channel further back in the queue cannot overtake the head.
  always_comb begin
    head_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (head.ch == CHW'(i)) head_ready = ready_in[i];
    end
  end

  assign pop  = (count != '0) & head_ready;
  assign push = push_req & ((count < CNTW'(DEPTH)) | pop);
  assign drop = push_req & ~push;

  // Write the storage array.
  // NOTE: the storage array has no reset. Entries are only read when count
  // says they are valid, so stale contents are never visible. Leaving out
  // the reset lets the array map onto plain RAM or register cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= frame;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_count = count;

  // Sticky overflow flag. A drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_err) overflow <= 1'b0;
  end

  // ---------------------------------------------------------------------
  // Dispatch registers
  // ---------------------------------------------------------------------
  // Pulse the head entry's channel for one cycle. The payload outputs hold
  // their last dispatched values until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= '0;
      cmd_vbit  <= 1'b0;
      opcode    <= '0;
      key_addr  <= '0;
      text_addr <= '0;
      dest_addr <= '0;
    end else begin
      cmd_valid <= '0;
      if (pop) begin
        cmd_valid <= NCH'(1) << head.ch;
        cmd_vbit  <= head.vbit;
        opcode    <= head.opcode;
        key_addr  <= head.key;
        text_addr <= head.text;
        dest_addr <= head.dest;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Directed bench for spi_cmd_queue. Instance "dut" uses the default
// parameters and is checked against a scoreboard of expected dispatches.
// Instance "dut3" uses NCH=3 to cover the out-of-range channel case.
module tb_spi_cmd_queue;

  logic clk = 1'b0;
  logic rst_n, spi_clk, mosi, cs_n_a, cs_n_b, clr_err;
  logic [1:0]  ready_a, cmd_valid_a, opcode_a;
  logic [2:0]  ready_b, cmd_valid_b, count_a, count_b;
  logic [1:0]  opcode_b;
  logic        vbit_a, vbit_b, ovf_a, ovf_b, ferr_a, ferr_b;
  logic [23:0] key_a, text_a, dest_a, key_b, text_b, dest_b;

  always #5 clk = ~clk;

  spi_cmd_queue dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n_a),
    .ready_in(ready_a), .clr_err(clr_err), .cmd_valid(cmd_valid_a),
    .cmd_vbit(vbit_a), .opcode(opcode_a), .key_addr(key_a), .text_addr(text_a),
    .dest_addr(dest_a), .fifo_count(count_a), .overflow(ovf_a), .frame_err(ferr_a)
  );

  spi_cmd_queue #(.NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n_b),
    .ready_in(ready_b), .clr_err(clr_err), .cmd_valid(cmd_valid_b),
    .cmd_vbit(vbit_b), .opcode(opcode_b), .key_addr(key_b), .text_addr(text_b),
    .dest_addr(dest_b), .fifo_count(count_b), .overflow(ovf_b), .frame_err(ferr_b)
  );

  typedef struct packed {
    logic [1:0]  cv;
    logic        vbit;
    logic [1:0]  op;
    logic [23:0] key, text, dest;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, pulses_a = 0, ferrs_a = 0, pulses_b = 0, ferrs_b = 0;
  int last_pulse = 0, prev_pulse = 0;
  logic [2:0] last_cv_b = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Score every dispatch pulse of dut against the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (ferr_a) ferrs_a++;
    if (cmd_valid_a != 2'b00) begin
      pulses_a++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 128'(cmd_valid_a), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("cmd_valid", 128'(cmd_valid_a), 128'(e.cv));
        chk("payload", 128'({vbit_a, opcode_a, key_a, text_a, dest_a}),
            128'({e.vbit, e.op, e.key, e.text, e.dest}));
      end
    end
  end

  // Count the pulses of dut3.
  always @(negedge clk) begin
    if (ferr_b) ferrs_b++;
    if (cmd_valid_b != 3'b000) begin
      pulses_b++;
      last_cv_b = cmd_valid_b;
    end
  end

  // Send the nbits LSBs of f, MSB first, to dut (which=0) or dut3 (which=1).
  task automatic spi_send(input int which, input logic [95:0] f, input int nbits);
    if (which == 0) cs_n_a = 1'b0; else cs_n_b = 1'b0;
    #100;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_clk = 1'b0; mosi = f[i]; #40;
      spi_clk = 1'b1; #40;
    end
    spi_clk = 1'b0; #40;
    cs_n_a = 1'b1; cs_n_b = 1'b1;
    #100;
  endtask

  // Send one full frame to dut. Queue the expected dispatch when it
  // should be accepted.
  task automatic send_cmd(input logic vb, input logic [1:0] op, input logic ch,
                          input logic [23:0] k, input logic [23:0] t,
                          input logic [23:0] d, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.cv = ch ? 2'b10 : 2'b01; e.vbit = vb; e.op = op;
      e.key = k; e.text = t; e.dest = d;
      exp_q.push_back(e);
    end
    spi_send(0, 96'({vb, op, ch, k, t, d}), 76);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int p0, f0;
    rst_n = 1'b0; spi_clk = 1'b0; mosi = 1'b0; cs_n_a = 1'b1; cs_n_b = 1'b1;
    clr_err = 1'b0; ready_a = 2'b00; ready_b = 3'b000;
    #35;
    chk("rst_outputs", 128'({cmd_valid_a, vbit_a, opcode_a, key_a, text_a, dest_a}), 128'(0));
    chk("rst_count", 128'({count_a, ovf_a, ferr_a}), 128'(0));
    rst_n = 1'b1;
    #50;

    // Single command to channel 1.
    ready_a = 2'b10;
    send_cmd(1'b1, 2'b10, 1'b1, 24'h000100, 24'h000200, 24'h000300, 1'b1);
    drain("basic_drain");
    repeat (5) @(negedge clk);
    chk("basic_count", 128'(count_a), 128'(0));
    chk("basic_pulses", 128'(pulses_a), 128'(1));
    chk("payload_hold", 128'({cmd_valid_a, key_a, dest_a}), 128'({2'b00, 24'h000100, 24'h000300}));

    // Fill the FIFO, overflow it, then drain in order and clear the flag.
    ready_a = 2'b00;
    p0 = pulses_a;
    for (int i = 0; i < 5; i++)
      send_cmd(1'b1, 2'(i), 1'(i), 24'(i + 16), 24'(i + 32), 24'(i + 48), i < 4);
    chk("ovf_count", 128'(count_a), 128'(4));
    chk("ovf_flag", 128'(ovf_a), 128'(1));
    chk("ovf_no_pulse", 128'(pulses_a), 128'(p0));
    ready_a = 2'b11;
    drain("ovf_drain");
    repeat (3) @(negedge clk);
    chk("ovf_pulses", 128'(pulses_a - p0), 128'(4));
    chk("ovf_sticky", 128'({count_a, ovf_a}), 128'({3'd0, 1'b1}));
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 128'(ovf_a), 128'(0));

    // Partial frame of 40 bits, then a good frame.
    f0 = ferrs_a;
    spi_send(0, 96'hA5A5_A5A5_A5, 40);
    chk("partial_ferr", 128'(ferrs_a - f0), 128'(1));
    chk("partial_count", 128'(count_a), 128'(0));
    ready_a = 2'b01;
    send_cmd(1'b0, 2'b01, 1'b0, 24'hABCDEF, 24'h123456, 24'h654321, 1'b1);
    drain("partial_drain");

    // Head-of-line blocking: a ch0 head blocks a ch1 entry behind it.
    ready_a = 2'b10;
    p0 = pulses_a;
    send_cmd(1'b1, 2'b11, 1'b0, 24'h00000A, 24'h00000B, 24'h00000C, 1'b1);
    send_cmd(1'b1, 2'b00, 1'b1, 24'h0000A0, 24'h0000B0, 24'h0000C0, 1'b1);
    chk("hol_count", 128'(count_a), 128'(2));
    chk("hol_blocked", 128'(pulses_a), 128'(p0));
    ready_a = 2'b11;
    drain("hol_drain");
    chk("hol_consecutive", 128'(last_pulse - prev_pulse), 128'(1));

    // Extra bits in the same CS window are ignored.
    f0 = ferrs_a;
    exp_q.push_back('{cv: 2'b10, vbit: 1'b1, op: 2'b01, key: 24'h111111,
                      text: 24'h222222, dest: 24'h333333});
    spi_send(0, 96'({1'b1, 2'b01, 1'b1, 24'h111111, 24'h222222, 24'h333333, 4'hF}), 80);
    drain("extra_drain");
    repeat (5) @(negedge clk);
    chk("extra_no_ferr", 128'({count_a, 32'(ferrs_a - f0)}), 128'(0));

    // dut3 with NCH=3: channel 3 is rejected, channel 2 is dispatched.
    spi_send(1, 96'({1'b1, 2'b01, 2'd3, 24'h1, 24'h2, 24'h3}), 77);
    chk("ch3_ferr", 128'(ferrs_b), 128'(1));
    chk("ch3_count", 128'({count_b, 32'(pulses_b)}), 128'(0));
    ready_b = 3'b100;
    spi_send(1, 96'({1'b1, 2'b11, 2'd2, 24'h77, 24'h88, 24'h99}), 77);
    repeat (10) @(negedge clk);
    chk("ch2_pulse", 128'({32'(pulses_b), last_cv_b}), 128'({32'd1, 3'b100}));
    chk("ch2_payload", 128'({opcode_b, key_b, dest_b}), 128'({2'b11, 24'h77, 24'h99}));

    // Reset with two entries queued discards them.
    ready_a = 2'b00;
    send_cmd(1'b1, 2'b10, 1'b0, 24'h5, 24'h6, 24'h7, 1'b1);
    send_cmd(1'b1, 2'b10, 1'b1, 24'h8, 24'h9, 24'hA, 1'b1);
    chk("rstq_count_before", 128'(count_a), 128'(2));
    @(negedge clk) rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstq_count", 128'(count_a), 128'(0));
    rst_n = 1'b1;
    p0 = pulses_a;
    ready_a = 2'b11;
    repeat (60) @(negedge clk);
    chk("rstq_no_pulse", 128'({count_a, 32'(pulses_a - p0)}), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no summary expected summary");
    $fatal(1, "timeout");
  end

endmodule
